// File: rtl/quad_encoder_emulator_if.sv
`default_nettype none
// ============================================================================
// Module   : quad_encoder_emulator_if
// Brief    : Command / encoder-output bundle for the quadrature encoder
//            emulator. The master side issues velocity and position loads;
//            the slave side (the emulator) returns A/B/Z and position.
// Revision : 1.0 - initial release
// ============================================================================
interface quad_encoder_emulator_if #(
  parameter int VEL_W = 16,
  parameter int POS_W = 32
);
  // Command side
  logic                    enable;
  logic signed [VEL_W-1:0] velocity;
  logic                    load_pos;
  logic signed [POS_W-1:0] pos_in;

  // Encoder side
  logic                    ENC_A;
  logic                    ENC_B;
  logic                    ENC_Z;
  logic signed [POS_W-1:0] position;
  logic                    step_pulse;
  logic                    dir;

  modport master (
    output enable, velocity, load_pos, pos_in,
    input  ENC_A, ENC_B, ENC_Z, position, step_pulse, dir
  );

  modport slave (
    input  enable, velocity, load_pos, pos_in,
    output ENC_A, ENC_B, ENC_Z, position, step_pulse, dir
  );
endinterface
`default_nettype wire

// File: rtl/quad_encoder_emulator.sv
`default_nettype none
// ============================================================================
// Module   : quad_encoder_emulator
// Brief    : Produces quadrature A/B and index Z from a signed velocity
//            command. A phase accumulator overflow marks each step; the A/B
//            pair walks a Gray sequence so only one line toggles per step.
// Revision : 1.0 - initial release
// ============================================================================
module quad_encoder_emulator #(
  parameter int PHASE_ACC_W = 16,
  parameter int VEL_W       = 16,
  parameter int POS_W       = 32,
  parameter int CPR         = 1320
) (
  input  wire logic            clk,
  input  wire logic            CPU_RESET,
  quad_encoder_emulator_if.slave bus
);

  // Revolution index needs to hold 0..CPR-1
  localparam int IDX_W = (CPR > 2) ? $clog2(CPR) : 1;
  localparam logic [IDX_W-1:0] c_idx_max = IDX_W'(CPR - 1);
  localparam logic [POS_W-1:0] c_pos_one = POS_W'(1);

  // A/B pair encoded directly as {A,B} so the outputs come straight off flops
  typedef enum logic [1:0] {
    AB_00 = 2'b00,
    AB_10 = 2'b10,
    AB_11 = 2'b11,
    AB_01 = 2'b01
  } ab_state_t;

  ab_state_t                r_ab;
  ab_state_t                w_ab_nxt;
  logic [PHASE_ACC_W-1:0]   r_acc;
  logic [PHASE_ACC_W-1:0]   w_acc_nxt;
  logic signed [POS_W-1:0]  r_pos;
  logic signed [POS_W-1:0]  w_pos_nxt;
  logic [IDX_W-1:0]         r_rev_idx;
  logic [IDX_W-1:0]         w_rev_idx_nxt;
  logic                     r_enc_z;
  logic                     r_step_pulse;
  logic                     r_dir;
  logic                     w_dir_nxt;

  logic [VEL_W:0]           w_vel_ext;
  logic [VEL_W:0]           w_mag;
  logic [PHASE_ACC_W:0]     w_mag_ext;
  logic [PHASE_ACC_W:0]     w_sum;
  logic                     w_carry;
  logic                     w_step;
  logic                     w_fwd;

  // Magnitude one bit wider than velocity so the most negative value is exact
  always_comb begin
    w_vel_ext = {bus.velocity[VEL_W-1], bus.velocity};
    if (w_vel_ext[VEL_W]) begin
      w_mag = ~w_vel_ext + (VEL_W+1)'(1);
    end else begin
      w_mag = w_vel_ext;
    end
    w_mag_ext            = '0;
    w_mag_ext[VEL_W:0]   = w_mag;
    w_sum                = {1'b0, r_acc} + w_mag_ext;
    w_carry              = w_sum[PHASE_ACC_W];
    // A carry implies nonzero velocity, so the sign bit alone picks direction
    w_fwd                = ~bus.velocity[VEL_W-1];
    // A position load suppresses any step due on the same edge
    w_step               = bus.enable & ~bus.load_pos & w_carry;
  end

  // Next A/B state: walk the Gray cycle one position per step
  always_comb begin
    w_ab_nxt = r_ab;
    if (w_step) begin
      if (w_fwd) begin
        case (r_ab)
          AB_00:   w_ab_nxt = AB_10;
          AB_10:   w_ab_nxt = AB_11;
          AB_11:   w_ab_nxt = AB_01;
          AB_01:   w_ab_nxt = AB_00;
          default: w_ab_nxt = AB_00;
        endcase
      end else begin
        case (r_ab)
          AB_00:   w_ab_nxt = AB_01;
          AB_01:   w_ab_nxt = AB_11;
          AB_11:   w_ab_nxt = AB_10;
          AB_10:   w_ab_nxt = AB_00;
          default: w_ab_nxt = AB_00;
        endcase
      end
    end
  end

  // Next accumulator, position, revolution index and direction
  always_comb begin
    w_acc_nxt     = r_acc;
    w_pos_nxt     = r_pos;
    w_rev_idx_nxt = r_rev_idx;
    w_dir_nxt     = r_dir;
    if (bus.load_pos) begin
      w_acc_nxt     = '0;
      w_pos_nxt     = bus.pos_in;
      w_rev_idx_nxt = '0;
    end else if (bus.enable) begin
      w_acc_nxt = w_sum[PHASE_ACC_W-1:0];
      if (w_step) begin
        w_dir_nxt = w_fwd;
        if (w_fwd) begin
          w_pos_nxt     = r_pos + c_pos_one;
          w_rev_idx_nxt = (r_rev_idx == c_idx_max) ? '0 : r_rev_idx + 1'b1;
        end else begin
          w_pos_nxt     = r_pos - c_pos_one;
          w_rev_idx_nxt = (r_rev_idx == '0) ? c_idx_max : r_rev_idx - 1'b1;
        end
      end
    end
  end

  // A/B state register
  always_ff @(posedge clk or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_ab <= AB_00;
    end else begin
      r_ab <= w_ab_nxt;
    end
  end

  // Phase, position, index and status registers
  always_ff @(posedge clk or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_acc        <= '0;
      r_pos        <= '0;
      r_rev_idx    <= '0;
      r_enc_z      <= 1'b1;
      r_step_pulse <= 1'b0;
      r_dir        <= 1'b0;
    end else begin
      r_acc        <= w_acc_nxt;
      r_pos        <= w_pos_nxt;
      r_rev_idx    <= w_rev_idx_nxt;
      r_enc_z      <= (w_rev_idx_nxt == '0);
      r_step_pulse <= w_step;
      r_dir        <= w_dir_nxt;
    end
  end

  assign bus.ENC_A      = r_ab[1];
  assign bus.ENC_B      = r_ab[0];
  assign bus.ENC_Z      = r_enc_z;
  assign bus.position   = r_pos;
  assign bus.step_pulse = r_step_pulse;
  assign bus.dir        = r_dir;

endmodule
`default_nettype wire

// File: doc/quad_encoder_emulator.md
Name: quad_encoder_emulator

Overview:
Generates quadrature encoder signals (ENC_A, ENC_B, index ENC_Z) from a signed velocity command. It is the transmit end of the encoder interface that the motor-control top decodes. It is used in benches and in hardware-in-the-loop builds to drive the encoder inputs without a physical motor. A phase accumulator sets the step rate, and a Gray-coded 2-bit state produces the A/B waveform.

Parameters:
PHASE_ACC_W, 16, phase accumulator width; step rate = |velocity| / 2^PHASE_ACC_W steps per clk.
VEL_W, 16, velocity command width (signed); must satisfy VEL_W <= PHASE_ACC_W.
POS_W, 32, position counter width (signed).
CPR, 1320, quadrature edges per revolution; used for index generation; must be >= 2.

Ports:
clk  input  1  system clock
CPU_RESET  input  1  asynchronous reset, active-high
enable  input  1  1 = run; 0 = freeze all state
velocity  input  VEL_W  signed; sign gives direction, magnitude is the phase increment
load_pos  input  1  one-cycle strobe; loads pos_in
pos_in  input  POS_W  signed position load value
ENC_A  output  1  quadrature channel A (registered)
ENC_B  output  1  quadrature channel B (registered)
ENC_Z  output  1  index; high while rev_idx == 0 (registered)
position  output  POS_W  signed edge count (registered)
step_pulse  output  1  one-cycle pulse in the cycle the A/B outputs change
dir  output  1  direction of the last step; 1 = forward, 0 = reverse

Behaviour:
- Reset (async, CPU_RESET=1):
  - acc=0, (A,B)=00, position=0, rev_idx=0.
  - ENC_Z=1, step_pulse=0, dir=0.
- Magnitude: mag = |velocity|, computed at VEL_W+1 bits so that the most negative velocity (-2^(VEL_W-1)) gives mag = 2^(VEL_W-1). Since mag < 2^PHASE_ACC_W, at most one step occurs per clk.
- Each clk with enable=1 and load_pos=0:
  - sum = acc + mag (PHASE_ACC_W+1 bits).
  - acc <= sum[PHASE_ACC_W-1:0].
  - carry = sum[PHASE_ACC_W].
- On carry=1, a step is taken at the same edge (zero added latency):
  - Forward (velocity > 0): (A,B) advances 00 -> 10 -> 11 -> 01 -> 00, so A leads B. position += 1. rev_idx = (rev_idx == CPR-1) ? 0 : rev_idx+1. dir <= 1.
  - Reverse (velocity < 0): (A,B) advances 00 -> 01 -> 11 -> 10 -> 00. position -= 1. rev_idx = (rev_idx == 0) ? CPR-1 : rev_idx-1. dir <= 0.
  - step_pulse <= 1 for exactly that cycle; otherwise 0.
- velocity=0: mag=0, so no carry. acc holds and outputs hold.
- Only one A/B bit changes per step. A/B never skip a state.
- position wraps in two's complement at POS_W; this is not an error.
- ENC_Z is registered and follows the next value of rev_idx. It is high for exactly one quadrature state per revolution.
- Direction reversal: acc is retained (no reset), so the residual phase carries across the sign change.
- enable=0: acc, A/B, position, rev_idx and dir hold. step_pulse=0. load_pos is still honoured.
- load_pos=1: position <= pos_in, rev_idx <= 0, acc <= 0. A/B and dir are unchanged. step_pulse=0.
  - If a step would occur in the same cycle, the load wins and the step is dropped.
- Reset mid-operation: all state returns to reset values immediately. The first step after release requires a full accumulation from acc=0.
- velocity is sampled every cycle, with no handshake. Changes take effect on the next edge.

Test Plan:
1. Hold CPU_RESET=1 with velocity=1000, enable=1 -> A=B=0, Z=1, position=0, step_pulse=0. Release reset -> no step for the first 65 edges; first step on edge 66 (ceil(65536/1000)).
2. velocity=16384, enable=1, from reset -> step every 4th edge. (A,B) = 10, 11, 01, 00 on edges 4, 8, 12, 16. position=4 after 16 edges, dir=1, one step_pulse per step.
3. velocity=-16384 from reset -> (A,B) = 01, 11, 10, 00. position = -1, -2, -3, -4. dir=0.
4. CPR=8, velocity=32767:
   - 8 forward steps: Z high only at step 0 and step 8, position=8.
   - Then velocity=-32768 for 1 step: rev_idx=7, Z=0, position=7. Steps then occur every 2 edges.
5. load_pos=1 with pos_in=-5 on an edge where a carry is due -> position=-5, A/B unchanged, step_pulse=0, acc=0. The next step occurs 4 edges later (velocity=16384).
6. velocity=16384, deassert enable for 10 cycles mid-phase -> all outputs frozen. Re-enable -> stepping resumes with the preserved acc phase.
